// File: rtl/adder8_reg.sv
// 8-bit ripple-carry adder with carry-in/carry-out and registered, valid-qualified outputs.
// The carry chain is a row of WIDTH full-adder cells; results appear one cycle after capture.
module adder8_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p      = a[i] ^ b[i];
        assign s[i]   = p ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    // NOTE: sum/cout are reset as well as out_valid so nothing downstream can
    // see a stale or X result after reset, even if it ignores out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Result registers load only on valid cycles, so junk on a/b never propagates.
            if (in_valid) begin
                sum  <= s;
                cout <= c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_adder8_reg.sv
// Directed-vector bench for adder8_reg: hand-computed sums, hold behaviour,
// X isolation while idle, and asynchronous reset between clock edges.
module tb_adder8_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       cin;
    logic       in_valid;
    logic [7:0] sum;
    logic       cout;
    logic       out_valid;

    int vectors = 0;
    int miscompares = 0;

    adder8_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, let the rising edge capture, check just after it.
    task automatic apply(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                         input logic [7:0] exp_sum, input logic exp_cout);
        string tag;
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        tag = $sformatf("%0d+%0d+%0d", va, vb, vc);
        check({tag, " sum"}, {1'b0, sum}, {1'b0, exp_sum});
        check({tag, " cout"}, {8'h0, cout}, {8'h0, exp_cout});
        check({tag, " valid"}, {8'h0, out_valid}, 9'h1);
    endtask

    initial begin
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
        #12;
        check("reset sum", {1'b0, sum}, 9'h0);
        check("reset cout", {8'h0, cout}, 9'h0);
        check("reset valid", {8'h0, out_valid}, 9'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back valid vectors: one result per cycle.
        for (int i = 0; i < 5; i++) apply(8'(i), 8'd250, 1'b0, 8'(250 + i), 1'b0);
        apply(8'd5,   8'd250, 1'b0, 8'd255, 1'b0);
        apply(8'd6,   8'd250, 1'b0, 8'd0,   1'b1);
        apply(8'd9,   8'd250, 1'b0, 8'd3,   1'b1);
        apply(8'd4,   8'd250, 1'b1, 8'd255, 1'b0);
        apply(8'd5,   8'd250, 1'b1, 8'd0,   1'b1);
        apply(8'd9,   8'd250, 1'b1, 8'd4,   1'b1);
        apply(8'd255, 8'd255, 1'b1, 8'd255, 1'b1);
        apply(8'd0,   8'd0,   1'b0, 8'd0,   1'b0);
        apply(8'hA5,  8'h5A,  1'b1, 8'h00,  1'b1);
        apply(8'd100, 8'd27,  1'b0, 8'd127, 1'b0);

        // Hold: new operands with in_valid low must not load.
        @(negedge clk);
        a = 8'd200; b = 8'd200; cin = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("hold sum", {1'b0, sum}, 9'd127);
        check("hold cout", {8'h0, cout}, 9'h0);
        check("hold valid", {8'h0, out_valid}, 9'h0);

        // Unknown operands while idle must not reach the outputs.
        @(negedge clk);
        a = 'x; b = 'x; cin = 1'bx;
        @(posedge clk); #1;
        check("x-idle sum", {1'b0, sum}, 9'd127);
        check("x-idle cout", {8'h0, cout}, 9'h0);

        // Async reset between edges: outputs clear without a clock edge.
        apply(8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
        @(negedge clk);
        a = 8'd1; b = 8'd1; cin = 1'b0; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async sum", {1'b0, sum}, 9'h0);
        check("async cout", {8'h0, cout}, 9'h0);
        check("async valid", {8'h0, out_valid}, 9'h0);
        @(posedge clk); #1;
        check("in-reset sum", {1'b0, sum}, 9'h0);
        check("in-reset valid", {8'h0, out_valid}, 9'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'd128, 8'd128, 1'b1, 8'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
